// File: rtl/rst_seq_pkg.sv
// Shared state encodings, default parameters and width helpers for the
// ordered reset sequencer.
package rst_seq_pkg;

  // One-hot state encoding.
  typedef enum logic [4:0] {
    S_WAIT_LOCK = 5'b00001,
    S_ASSERT    = 5'b00010,
    S_WAIT_DONE = 5'b00100,
    S_DONE      = 5'b01000,
    S_FAIL      = 5'b10000
  } state_e;

  localparam int DEF_NUM_STAGE      = 4;
  localparam int DEF_HOLD_CYCLES    = 64;
  localparam int DEF_TIMEOUT_CYCLES = 65535;
  localparam int DEF_MAX_RETRY      = 3;

  function automatic int stage_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int retry_w(input int max_retry);
    return $clog2(max_retry + 2);
  endfunction

  // One counter serves both the hold and the timeout, so size it for the larger.
  function automatic int timer_w(input int hold, input int tmo);
    return $clog2(((hold > tmo) ? hold : tmo) + 1);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Saturating up-counter with synchronous clear; hit_o flags that the count
// has reached the selected limit.
module rst_seq_timer #(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] limit_i,
  output logic          hit_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != '1))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign hit_o = (cnt_q >= limit_i);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Ordered reset sequencer: holds all stage resets, then releases stages one by
// one with per-stage timeout and bounded retry. RST_SEQ_WATCHDOG_EN adds a DONE-state watchdog.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGE      = DEF_NUM_STAGE,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_RETRY      = DEF_MAX_RETRY,
  localparam int SW = stage_w(NUM_STAGE),
  localparam int RW = retry_w(MAX_RETRY)
) (
  input  logic                 eth_gtx_clk,
  input  logic                 g_resetn,
  input  logic                 dcm_locked,
  input  logic                 start,
  input  logic [NUM_STAGE-1:0] stage_done,
  output logic [NUM_STAGE-1:0] stage_resetn,
  output logic                 seq_done,
  output logic                 seq_fail,
  output logic [SW-1:0]        fail_stage,
  output logic [RW-1:0]        retry_cnt
);

  localparam int            CW        = timer_w(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] HOLD_LIM  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LIM   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] LAST_K    = SW'(NUM_STAGE - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_SAT = RW'(MAX_RETRY + 1);

  state_e               state_q, state_d;
  logic [SW-1:0]        k_q, k_d, fail_stage_q, fail_stage_d, fault_stage;
  logic [RW-1:0]        retry_q, retry_d;
  logic [NUM_STAGE-1:0] srn_q, srn_d;
  logic                 done_q, fail_q, fault;
  logic                 tmr_clr, tmr_en, tmr_hit;
  logic [CW-1:0]        tmr_lim;
  logic                 wd_trip;
  logic [SW-1:0]        wd_stage;

  rst_seq_timer #(.CW(CW)) u_timer (
    .clk_i   (eth_gtx_clk),
    .rst_ni  (g_resetn),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .limit_i (tmr_lim),
    .hit_o   (tmr_hit)
  );

`ifdef RST_SEQ_WATCHDOG_EN
  // Remembers which ready flags were low on the previous DONE cycle.
  logic [NUM_STAGE-1:0] wd_low_q;

  always_ff @(posedge eth_gtx_clk or negedge g_resetn) begin
    if (!g_resetn) wd_low_q <= '0;
    else           wd_low_q <= (state_q == S_DONE) ? ~stage_done : '0;
  end

  always_comb begin
    wd_trip  = 1'b0;
    wd_stage = '0;
    for (int i = NUM_STAGE - 1; i >= 0; i--) begin
      if (wd_low_q[i] && !stage_done[i]) begin
        wd_trip  = 1'b1;
        wd_stage = SW'(i);
      end
    end
  end
`else
  assign wd_trip  = 1'b0;
  assign wd_stage = '0;
`endif

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    fail_stage_d = fail_stage_q;
    retry_d      = retry_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    tmr_lim      = (state_q == S_ASSERT) ? HOLD_LIM : TMO_LIM;
    fault        = 1'b0;
    fault_stage  = k_q;
    // Lock loss overrides everything; WAIT_LOCK also just idles here.
    if (!dcm_locked) begin
      state_d = S_WAIT_LOCK;
    end else begin
      case (state_q)
        S_WAIT_LOCK: begin
          state_d = S_ASSERT;
          tmr_clr = 1'b1;
        end
        S_ASSERT: begin
          tmr_en = 1'b1;
          if (tmr_hit) begin
            state_d = S_WAIT_DONE;
            k_d     = '0;
            tmr_clr = 1'b1;
          end
        end
        S_WAIT_DONE: begin
          tmr_en = 1'b1;
          if (stage_done[k_q]) begin
            tmr_clr = 1'b1;
            if (k_q == LAST_K) state_d = S_DONE;
            else               k_d     = k_q + SW'(1);
          end else if (tmr_hit) begin
            fault = 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state_d = S_ASSERT;
            retry_d = '0;
            tmr_clr = 1'b1;
          end else if (wd_trip) begin
            fault       = 1'b1;
            fault_stage = wd_stage;
          end
        end
        S_FAIL: begin
          if (start) begin
            state_d = S_ASSERT;
            retry_d = '0;
            tmr_clr = 1'b1;
          end
        end
        default: state_d = S_WAIT_LOCK;
      endcase
      if (fault) begin
        fail_stage_d = fault_stage;
        retry_d      = (retry_q == RETRY_SAT) ? retry_q : retry_q + RW'(1);
        state_d      = (retry_q < RETRY_MAX) ? S_ASSERT : S_FAIL;
        tmr_clr      = 1'b1;
      end
    end
  end

  always_comb begin
    srn_d = '0;
    for (int i = 0; i < NUM_STAGE; i++)
      srn_d[i] = (state_d == S_DONE) || ((state_d == S_WAIT_DONE) && (i <= int'(k_d)));
  end

  always_ff @(posedge eth_gtx_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q      <= S_WAIT_LOCK;
      k_q          <= '0;
      fail_stage_q <= '0;
      retry_q      <= '0;
      srn_q        <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      fail_stage_q <= fail_stage_d;
      retry_q      <= retry_d;
      srn_q        <= srn_d;
      done_q       <= (state_d == S_DONE);
      fail_q       <= (state_d == S_FAIL);
    end
  end

  assign stage_resetn = srn_q;
  assign seq_done     = done_q;
  assign seq_fail     = fail_q;
  assign fail_stage   = fail_stage_q;
  assign retry_cnt    = retry_q;

endmodule
